// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control and the ALU control decoder.
package multicycle_control_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp encodings, shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; codes 14 and 15 are unused and recover to StReset
  typedef enum logic [3:0] {
    StReset   = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExecR   = 4'd7,
    StRwb     = 4'd8,
    StExecI   = 4'd9,
    StIwb     = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12,
    StIllegal = 4'd13
  } state_e;

  // Full set of datapath control outputs
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode and memory handshake in, enables out.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;

  // Controller side
  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op
  );

  // Datapath / memory side
  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control output map. Only FETCH and MEMWR look at mem_ready.
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctl_t   ctl_o
);

  // Moore decode with all outputs defaulting to 0
  always_comb begin
    ctl_o = '0;
    case (state_i)
      StFetch: begin
        ctl_o.mem_read  = 1'b1;
        ctl_o.alu_src_b = SRCB_FOUR;
        ctl_o.alu_op    = ALUOP_ADD;
        ctl_o.pc_source = PCSRC_ALU;
        // PC and IR load only on the completing cycle so a stall never double-increments
        ctl_o.ir_write  = mem_ready_i;
        ctl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctl_o.alu_src_b = SRCB_IMM_SH2;
        ctl_o.alu_op    = ALUOP_ADD;
      end
      StMemAddr, StExecI: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = SRCB_IMM;
        ctl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctl_o.mem_read = 1'b1;
        ctl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctl_o.reg_write  = 1'b1;
        ctl_o.mem_to_reg = 1'b1;
        ctl_o.instr_done = 1'b1;
      end
      StMemWr: begin
        ctl_o.mem_write  = 1'b1;
        ctl_o.i_or_d     = 1'b1;
        ctl_o.instr_done = mem_ready_i;
      end
      StExecR: begin
        ctl_o.alu_src_a = 1'b1;
        ctl_o.alu_src_b = SRCB_B;
        ctl_o.alu_op    = ALUOP_FUNC;
      end
      StRwb: begin
        ctl_o.reg_write  = 1'b1;
        ctl_o.reg_dst    = 1'b1;
        ctl_o.instr_done = 1'b1;
      end
      StIwb: begin
        ctl_o.reg_write  = 1'b1;
        ctl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctl_o.alu_src_a     = 1'b1;
        ctl_o.alu_src_b     = SRCB_B;
        ctl_o.alu_op        = ALUOP_SUB;
        ctl_o.pc_write_cond = 1'b1;
        ctl_o.pc_source     = PCSRC_ALUOUT;
        ctl_o.instr_done    = 1'b1;
      end
      StJump: begin
        ctl_o.pc_write   = 1'b1;
        ctl_o.pc_source  = PCSRC_JUMP;
        ctl_o.instr_done = 1'b1;
      end
      // Terminal state, so decoding from state alone keeps illegal_op sticky until reset
      StIllegal: ctl_o.illegal_op = 1'b1;
      default: ctl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, opcode latch,
// next-state logic; output decode lives in control_decode.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  ctl_t       ctl;

  // State and opcode registers; reset forces StReset so every output drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StReset;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Opcode is captured only on the DECODE cycle
  always_comb begin
    opcode_d = opcode_q;
    if (state_q == StDecode) opcode_d = bus.Opcode;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExecR;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StExecI;
          default:      state_d = StIllegal;
        endcase
      end
      StMemAddr: state_d = (opcode_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StExecR:   state_d = StRwb;
      StRwb:     state_d = StFetch;
      StExecI:   state_d = StIwb;
      StIwb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StIllegal: state_d = StIllegal;
      default:   state_d = StReset;
    endcase
  end

  control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctl_o       (ctl)
  );

  assign bus.PCWrite     = ctl.pc_write;
  assign bus.PCWriteCond = ctl.pc_write_cond;
  assign bus.IorD        = ctl.i_or_d;
  assign bus.MemRead     = ctl.mem_read;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.ALUOp       = ctl.alu_op;
  assign bus.PCSource    = ctl.pc_source;
  assign bus.instr_done  = ctl.instr_done;
  assign bus.illegal_op  = ctl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle and
// compares the full control vector against hand-written per-state expectations.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  //                ALUSrcA _ ALUSrcB _ ALUOp _ PCSource _ instr_done _ illegal_op
  localparam logic [17:0] V_ZERO    = 18'b0000000000_00_00_00_0_0;
  localparam logic [17:0] V_FETCH_W = 18'b0001000000_01_00_00_0_0;
  localparam logic [17:0] V_FETCH_R = 18'b1001010000_01_00_00_0_0;
  localparam logic [17:0] V_DECODE  = 18'b0000000000_11_00_00_0_0;
  localparam logic [17:0] V_ADDR    = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] V_MEMRD   = 18'b0011000000_00_00_00_0_0;
  localparam logic [17:0] V_MEMWB   = 18'b0000001010_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR_W = 18'b0010100000_00_00_00_0_0;
  localparam logic [17:0] V_MEMWR_R = 18'b0010100000_00_00_00_1_0;
  localparam logic [17:0] V_EXECR   = 18'b0000000001_00_10_00_0_0;
  localparam logic [17:0] V_RWB     = 18'b0000000110_00_00_00_1_0;
  localparam logic [17:0] V_IWB     = 18'b0000000010_00_00_00_1_0;
  localparam logic [17:0] V_BRANCH  = 18'b0100000001_00_01_01_1_0;
  localparam logic [17:0] V_JUMP    = 18'b1000000000_00_00_10_1_0;
  localparam logic [17:0] V_ILLEGAL = 18'b0000000000_00_00_00_0_1;

  function automatic logic [17:0] observed();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSource, bus.instr_done, bus.illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock, apply inputs for the new cycle, then check the outputs
  task automatic cyc(input logic rdy, input logic [5:0] op, input string tag,
                     input logic [17:0] exp);
    @(posedge clk);
    #2;
    bus.mem_ready = rdy;
    bus.Opcode    = op;
    #1;
    chk(tag, exp);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Opcode    = 6'b000000;
    #12;
    chk("reset_outputs", V_ZERO);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type: FETCH DECODE EXEC_R RWB, done only in cycle 4
    cyc(1'b1, 6'b000000, "r_fetch",  V_FETCH_R);
    cyc(1'b0, 6'b000000, "r_decode", V_DECODE);
    cyc(1'b0, 6'b000000, "r_exec",   V_EXECR);
    cyc(1'b0, 6'b000000, "r_wb",     V_RWB);

    // LW with a fetch stall and 3 wait cycles in MEMRD; opcode input changes after DECODE
    cyc(1'b0, 6'b000000, "lw_fetch_wait", V_FETCH_W);
    cyc(1'b1, 6'b000000, "lw_fetch",      V_FETCH_R);
    cyc(1'b0, 6'b100011, "lw_decode",     V_DECODE);
    cyc(1'b0, 6'b101011, "lw_addr",       V_ADDR);
    cyc(1'b0, 6'b101011, "lw_memrd1",     V_MEMRD);
    cyc(1'b0, 6'b101011, "lw_memrd2",     V_MEMRD);
    cyc(1'b0, 6'b101011, "lw_memrd3",     V_MEMRD);
    cyc(1'b1, 6'b101011, "lw_memrd4",     V_MEMRD);
    cyc(1'b0, 6'b101011, "lw_memwb",      V_MEMWB);

    // BEQ
    cyc(1'b1, 6'b000000, "beq_fetch",  V_FETCH_R);
    cyc(1'b0, 6'b000100, "beq_decode", V_DECODE);
    cyc(1'b0, 6'b000000, "beq_branch", V_BRANCH);

    // J
    cyc(1'b1, 6'b000000, "j_fetch",  V_FETCH_R);
    cyc(1'b0, 6'b000010, "j_decode", V_DECODE);
    cyc(1'b0, 6'b000000, "j_jump",   V_JUMP);

    // SW with one write wait; opcode input flips to LW after DECODE
    cyc(1'b1, 6'b000000, "sw_fetch",     V_FETCH_R);
    cyc(1'b0, 6'b101011, "sw_decode",    V_DECODE);
    cyc(1'b0, 6'b100011, "sw_addr",      V_ADDR);
    cyc(1'b0, 6'b100011, "sw_memwr_wait", V_MEMWR_W);
    cyc(1'b1, 6'b100011, "sw_memwr_done", V_MEMWR_R);

    // ADDI
    cyc(1'b1, 6'b000000, "addi_fetch",  V_FETCH_R);
    cyc(1'b0, 6'b001000, "addi_decode", V_DECODE);
    cyc(1'b0, 6'b000000, "addi_exec",   V_ADDR);
    cyc(1'b0, 6'b000000, "addi_wb",     V_IWB);
    cyc(1'b0, 6'b000000, "addi_next_fetch", V_FETCH_W);

    // Asynchronous reset in the middle of a MEMRD wait
    cyc(1'b1, 6'b000000, "abort_fetch",  V_FETCH_R);
    cyc(1'b0, 6'b100011, "abort_decode", V_DECODE);
    cyc(1'b0, 6'b000000, "abort_addr",   V_ADDR);
    cyc(1'b0, 6'b000000, "abort_memrd",  V_MEMRD);
    rst_n = 1'b0;
    #1;
    chk("abort_reset_immediate", V_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 6'b000000, "abort_refetch", V_FETCH_W);

    // Illegal opcode: terminal and sticky, no memory requests even with mem_ready high
    cyc(1'b1, 6'b000000, "ill_fetch",  V_FETCH_R);
    cyc(1'b1, 6'b111111, "ill_decode", V_DECODE);
    cyc(1'b1, 6'b000000, "ill_state1", V_ILLEGAL);
    cyc(1'b1, 6'b000000, "ill_state2", V_ILLEGAL);
    cyc(1'b1, 6'b100011, "ill_state3", V_ILLEGAL);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ill_reset_clears", V_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 6'b000000, "ill_refetch", V_FETCH_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath, directly upstream of the ALU control decoder. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables and the 2-bit ALUOp that the ALU control decoder combines with FuncCode. Memory accesses wait on a ready handshake, so variable-latency memory is supported.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_J, 6'b000010, jump
OP_ADDI, 6'b001000, add immediate

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  6  IR[31:26]; sampled only in DECODE
mem_ready  input  1  memory has completed the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  0=ALUOut, 1=MDR to register file
RegDst  output  1  0=rt, 1=rd
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=use FuncCode
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse on the final state of each instruction
illegal_op  output  1  sticky: unsupported opcode decoded

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are decoded combinationally from the state only, except the mem_ready qualification noted below. Unlisted outputs are 0 in each state.
- Reset: while rst_n is low, the state is RESET asynchronously and all outputs are 0, including illegal_op. On the first edge after release, RESET -> FETCH.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1, and the state then moves to DECODE.
  - If mem_ready=0, the state stays in FETCH with all other outputs held. The PC is not written twice.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - LW or SW -> MEMADDR
  - RTYPE -> EXEC_R
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> EXEC_I
  - any other -> ILLEGAL
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if the latched opcode is LW, otherwise MEMWR.
- MEMRD: MemRead=1, IorD=1. Stays until mem_ready=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Stays until mem_ready=1. instr_done=1 in the mem_ready cycle, then -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- ILLEGAL:
  - illegal_op is set, and the state stays in ILLEGAL until reset (terminal).
  - No enables or memory requests are asserted.
- Opcode is latched into a 6-bit register on the DECODE cycle; MEMADDR uses the latched copy.
- Illegal encodings of the state register go to RESET on the next edge.
- Reset asserted mid-instruction (including during a memory wait) aborts immediately. No write enable may glitch high.
- Instruction latencies with mem_ready tied 1:
  - LW = 5 cycles
  - SW, R-type and ADDI = 4 cycles
  - BEQ and J = 3 cycles

Decomposition:
- Shared package: the opcode constants; the ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10), which the ALU control decoder also uses; the ALUSrcB and PCSource encodings; the state encodings.
- One sub-module, control_decode: a purely combinational state -> output map. It is instantiated by multicycle_control, which keeps the state register, next-state logic and opcode latch.

Test Plan:
- Reset with rst_n=0 mid-MEMRD -> all outputs 0 immediately. After release, FETCH is reached on the next edge with MemRead=1 and ALUSrcB=01.
- R-type (Opcode=000000), mem_ready=1 -> state sequence FETCH, DECODE, EXEC_R, RWB. ALUOp=10 in EXEC_R. RegWrite=1 and RegDst=1 in RWB. instr_done pulses once, in cycle 4.
- LW (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD is held 4 cycles with MemRead=1 and IorD=1. MEMWB follows with MemtoReg=1. Total is 8 cycles.
- BEQ (000100) -> ALUOp=01, PCWriteCond=1 and PCSource=01 in cycle 3, then back to FETCH. J (000010) -> PCWrite=1 and PCSource=10 in cycle 3.
- SW (101011) -> MemWrite=1 only in MEMWR and RegWrite is never asserted. ADDI (001000) -> ALUSrcB=10 and ALUOp=00, then RegWrite=1 with RegDst=0.
- Opcode=111111 -> ILLEGAL after DECODE, illegal_op=1 and held, no further MemRead. Pulsing rst_n low clears illegal_op.
